// File: rtl/als_meter_avg.sv
// als_meter_avg: ambient-light meter for the PMOD ALS sensor.
// Periodically reads the sensor over SPI, smooths the samples with a
// power-of-two moving average and drives an LED bank as PWM or a bar graph.
// Optional feature macro: ALS_PEAK_HOLD_EN adds peak_clr_i / peak_o and a
// peak dot in bar mode.
module als_meter_avg #(
    parameter int unsigned NUM_LEDS      = 8,
    parameter int unsigned SAMPLE_PERIOD = 200,
    parameter int unsigned SCK_DIV       = 4,
    parameter int unsigned AVG_LOG2      = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mode_i,
`ifdef ALS_PEAK_HOLD_EN
    input  logic                peak_clr_i,
    output logic [7:0]          peak_o,
`endif
    output logic [NUM_LEDS-1:0] leds_o,
    output logic [7:0]          avg_o,
    output logic                avg_valid_o,
    output logic                overrun_o,
    output logic                cs_o,
    output logic                sck_o,
    input  logic                sdo_i
);
    localparam int unsigned TW    = $clog2(SAMPLE_PERIOD);
    localparam int unsigned DW    = $clog2(2 * SCK_DIV);
    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SW    = 8 + AVG_LOG2;

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StDone} state_e;

    logic [TW-1:0]       tcnt_q;
    logic                req;
    state_e              state_q;
    logic [DW-1:0]       div_q;
    logic [3:0]          bit_q;
    logic [15:0]         shreg_q;
    logic                cs_q;
    logic                sck_q;
    logic [7:0]          sample;
    logic [7:0]          buf_q [DEPTH];
    logic [PW-1:0]       wptr_q;
    logic [SW-1:0]       sum_q;
    logic [SW-1:0]       sum_d;
    logic [7:0]          avg_q;
    logic                valid_q;
    logic [7:0]          pcnt_q;
    logic [7:0]          duty_q;
    logic [15:0]         bar_prod;
    logic [7:0]          lit;
    logic [NUM_LEDS-1:0] leds_d;
    logic [NUM_LEDS-1:0] leds_q;

    assign req       = (tcnt_q == '0);
    assign overrun_o = req && (state_q != StIdle);
    assign sample    = shreg_q[11:4];
    assign sum_d     = sum_q + SW'(sample) - SW'(buf_q[wptr_q]);

    // Request timer: free-running 0..SAMPLE_PERIOD-1, request fires at 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tcnt_q <= '0;
        end else if (tcnt_q == TW'(SAMPLE_PERIOD - 1)) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end

    // SPI frame FSM with registered cs/sck; sdo sampled on the edge that raises sck.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        cs_q    <= 1'b0;
                        div_q   <= '0;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (div_q == DW'(SCK_DIV - 1)) begin
                        div_q   <= '0;
                        bit_q   <= '0;
                        sck_q   <= 1'b0;
                        state_q <= StShift;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StShift: begin
                    if (div_q == DW'(SCK_DIV - 1)) begin
                        sck_q   <= 1'b1;
                        shreg_q <= {shreg_q[14:0], sdo_i};
                    end
                    if (div_q == DW'(2 * SCK_DIV - 1)) begin
                        div_q <= '0;
                        if (bit_q == 4'd15) begin
                            cs_q    <= 1'b1;
                            state_q <= StHold;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                            sck_q <= 1'b0;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StHold: begin
                    if (div_q == DW'(SCK_DIV - 1)) begin
                        div_q   <= '0;
                        state_q <= StDone;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Moving average: replace the oldest entry and publish the new mean next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wptr_q  <= '0;
            sum_q   <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (state_q == StDone) begin
                buf_q[wptr_q] <= sample;
                sum_q         <= sum_d;
                avg_q         <= 8'(sum_d >> AVG_LOG2);
                valid_q       <= 1'b1;
                wptr_q        <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            end
        end
    end

    // PWM counter; duty only reloads at the period boundary to avoid glitches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt_q <= '0;
            duty_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + 8'd1;
            if (pcnt_q == 8'hff) begin
                duty_q <= avg_q;
            end
        end
    end

`ifdef ALS_PEAK_HOLD_EN
    logic [7:0]  peak_q;
    logic [15:0] peak_prod;
    logic [7:0]  peak_lit;

    assign peak_o    = peak_q;
    assign peak_prod = 16'(peak_q) * 16'(NUM_LEDS + 1);
    assign peak_lit  = peak_prod[15:8];

    // Peak tracker: clear loads the current average, otherwise keep the maximum.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            peak_q <= '0;
        end else if (peak_clr_i) begin
            peak_q <= avg_q;
        end else if (valid_q && (avg_q > peak_q)) begin
            peak_q <= avg_q;
        end
    end
`endif

    // LED pattern: thermometer in bar mode, common PWM level otherwise.
    always_comb begin
        leds_d   = '0;
        bar_prod = 16'(avg_q) * 16'(NUM_LEDS + 1);
        lit      = bar_prod[15:8];
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            if (mode_i) begin
                leds_d[i] = ({24'd0, lit} > i);
`ifdef ALS_PEAK_HOLD_EN
                if (peak_lit == 8'(i + 1)) begin
                    leds_d[i] = 1'b1;
                end
`endif
            end else begin
                leds_d[i] = (pcnt_q < duty_q);
            end
        end
    end

    // Registered LED outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            leds_q <= '0;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign leds_o      = leds_q;
    assign avg_o       = avg_q;
    assign avg_valid_o = valid_q;
    assign cs_o        = cs_q;
    assign sck_o       = sck_q;

endmodule

// File: tb/tb_als_meter_avg.sv
// Bench for als_meter_avg: randomized SPI sensor model, moving-average
// reference model with an expected-value queue and a separate monitor.
module tb_als_meter_avg;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_i, rst2, mode_i, sdo_i;
    logic [N-1:0] leds_o, leds2;
    logic [7:0]   avg_o, avg2;
    logic         avg_valid_o, overrun_o, cs_o, sck_o;
    logic         valid2, ovr2, cs2, sck2;
`ifdef ALS_PEAK_HOLD_EN
    logic [7:0]   peak1, peak2;
`endif

    always #5 clk = ~clk;

    als_meter_avg #(.NUM_LEDS(N)) dut (
        .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i),
`ifdef ALS_PEAK_HOLD_EN
        .peak_clr_i(1'b0), .peak_o(peak1),
`endif
        .leds_o(leds_o), .avg_o(avg_o), .avg_valid_o(avg_valid_o),
        .overrun_o(overrun_o), .cs_o(cs_o), .sck_o(sck_o), .sdo_i(sdo_i)
    );

    als_meter_avg #(.NUM_LEDS(N), .SAMPLE_PERIOD(100)) dut2 (
        .clk_i(clk), .rst_i(rst2), .mode_i(1'b0),
`ifdef ALS_PEAK_HOLD_EN
        .peak_clr_i(1'b0), .peak_o(peak2),
`endif
        .leds_o(leds2), .avg_o(avg2), .avg_valid_o(valid2),
        .overrun_o(ovr2), .cs_o(cs2), .sck_o(sck2), .sdo_i(1'b0)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Reference model: mean of the last four samples, missing ones count as zero.
    int unsigned hist[$];
    int unsigned exp_q[$];
    logic [15:0] frame_q[$];
    int unsigned model_avg = 0, model_avg_prev = 0;
    int          n_valid = 0, ovr1 = 0;
    int          rises = 0;
    bit          in_frame = 0;
    bit          dut2_done = 0;

    function automatic int unsigned model_push(input int unsigned s);
        int unsigned sum = 0;
        hist.push_back(s);
        if (hist.size() > 4) void'(hist.pop_front());
        foreach (hist[i]) sum += hist[i];
        return sum / 4;
    endfunction

    function automatic logic [N-1:0] bar_mask(input int unsigned a);
        int unsigned lit = (a * (N + 1)) / 256;
        return N'((1 << lit) - 1);
    endfunction

    // Sensor model: new bit on each falling sck, expected average queued per full frame.
    initial begin
        logic [15:0] cur;
        logic        prev_sck;
        sdo_i = 1'b0;
        prev_sck = 1'b1;
        cur = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                in_frame = 0;
                hist.delete();
                prev_sck = 1'b1;
            end else begin
                if (!in_frame && !cs_o) begin
                    in_frame = 1;
                    rises = 0;
                    if (frame_q.size() > 0) cur = frame_q.pop_front();
                    else cur = 16'($urandom);
                end
                if (in_frame) begin
                    if (prev_sck && !sck_o && rises < 16) sdo_i = cur[15 - rises];
                    if (!prev_sck && sck_o) rises++;
                    if (cs_o) begin
                        in_frame = 0;
                        chk("sck_rises_per_frame", rises, 16);
                        if (rises == 16) exp_q.push_back(model_push(cur[11:4]));
                    end
                end
                prev_sck = sck_o;
            end
        end
    end

    // Monitor: pop and compare on every avg_valid_o; bar pattern checked the cycle after.
    initial begin
        bit          prev_valid = 0;
        bit          bar_pending = 0;
        int unsigned e;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                exp_q.delete();
                prev_valid = 0;
                bar_pending = 0;
                model_avg = 0;
                model_avg_prev = 0;
            end else begin
                if (overrun_o) ovr1++;
                if (bar_pending) begin
                    bar_pending = 0;
                    if (mode_i) chk("bar_leds", leds_o, bar_mask(model_avg));
                end
                if (avg_valid_o) begin
                    n_valid++;
                    if (prev_valid) fail_now("avg_valid_wider_than_one_cycle");
                    if (exp_q.size() == 0) begin
                        fail_now("avg_valid_without_frame");
                    end else begin
                        e = exp_q.pop_front();
                        chk("avg_value", avg_o, e);
                        model_avg_prev = model_avg;
                        model_avg = e;
                        if (mode_i) bar_pending = 1;
                    end
                end
                prev_valid = avg_valid_o;
            end
        end
    end

    task automatic wait_valids(input int n);
        int tgt = n_valid + n;
        int t = 0;
        while (n_valid < tgt && t < n * 300 + 400) begin
            @(negedge clk);
            t++;
        end
        if (n_valid < tgt) fail_now("avg_valid_timeout");
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_i = 1'b1;
        frame_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    function automatic logic [15:0] mk_frame(input logic [7:0] s);
        logic [3:0] hi = 4'($urandom);
        logic [3:0] lo = 4'($urandom);
        return {hi, s, lo};
    endfunction

    // Second instance with a short request period: every other request overruns.
    initial begin
        int   falls = 0, ovr = 0, run = 0;
        logic prev_cs = 1'b1;
        wait (rst2 == 1'b0);
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk);
            #1;
            if (ovr2) ovr++;
            if (!cs2) run++;
            if (prev_cs && !cs2) falls++;
            if (!prev_cs && cs2) begin
                chk("overrun_inst_frame_len", run, 132);
                run = 0;
            end
            prev_cs = cs2;
        end
        chk("overrun_inst_frames", falls, 10);
        chk("overrun_inst_pulses", ovr, 10);
        dut2_done = 1;
    end

    int lit_tab[5] = '{0, 0, 1, 4, 8};
    int val_tab[5] = '{0, 28, 29, 128, 255};

    initial begin
        int n, hi, bad, cnt;
        int unsigned a, b;
        logic prev0;
        rst_i = 1'b1;
        rst2 = 1'b1;
        mode_i = 1'b0;
        #1;
        chk("reset_outputs", {cs_o, sck_o, leds_o, avg_o, avg_valid_o, overrun_o},
            {1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        for (int i = 0; i < 4; i++) frame_q.push_back(16'h0FF0);
        @(negedge clk);
        rst_i = 1'b0;
        rst2 = 1'b0;

        // First frame: cs falls one cycle after release, low for 132 cycles.
        @(posedge clk);
        #1;
        chk("cs_first_fall", cs_o, 1'b0);
        n = 0;
        while (cs_o === 1'b0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("cs_low_cycles", n, 132);
        wait_valids(4);
        chk("ramp_final_avg", avg_o, 255);

        // Constant 0x80 for four frames then zero.
        do_reset();
        for (int i = 0; i < 4; i++) frame_q.push_back(16'h0800);
        frame_q.push_back(16'h0000);
        wait_valids(5);
        chk("const_then_zero_avg", avg_o, 96);

        // Bar graph boundaries.
        mode_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) frame_q.push_back(mk_frame(8'(val_tab[k])));
            wait_valids(4);
            chk("bar_avg_target", avg_o, val_tab[k]);
            @(negedge clk);
            chk("bar_lit_count", $countones(leds_o), lit_tab[k]);
        end

        // PWM with a steady average of 64.
        do_reset();
        mode_i = 1'b0;
        for (int i = 0; i < 10; i++) frame_q.push_back(mk_frame(8'd64));
        wait_valids(4);
        repeat (300) @(negedge clk);
        hi = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (leds_o == {N{1'b1}}) hi++;
            else if (leds_o != '0) bad++;
        end
        chk("pwm_on_count", hi, 64);
        chk("pwm_leds_uniform", bad, 0);

        // Switch to bar mode during the off phase; visible on the next cycle.
        n = 0;
        while (leds_o != '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        mode_i = 1'b1;
        @(posedge clk);
        #1;
        chk("mode_switch_bar", leds_o, bar_mask(64));
        @(negedge clk);
        mode_i = 1'b0;

        // PWM with a changing average: each period shows one duty from a boundary.
        for (int i = 0; i < 10; i++) frame_q.push_back(mk_frame(8'($urandom_range(16, 255))));
        prev0 = leds_o[0];
        for (int p = 0; p < 5; p++) begin
            n = 0;
            while (!(prev0 == 1'b0 && leds_o[0] == 1'b1) && n < 600) begin
                prev0 = leds_o[0];
                @(negedge clk);
                n++;
            end
            if (n >= 600) begin
                fail_now("pwm_period_start_timeout");
            end else begin
                a = model_avg;
                b = model_avg_prev;
                cnt = 0;
                for (int i = 0; i < 256; i++) begin
                    if (leds_o[0]) cnt++;
                    prev0 = leds_o[0];
                    @(negedge clk);
                end
                checks++;
                if (cnt != int'(a) && cnt != int'(b)) begin
                    failures++;
                    $display("FAIL pwm_period_duty: actual=%0d required=%0d or %0d", cnt, a, b);
                end
            end
        end

        // Reset in the middle of a frame.
        n = 0;
        while (!(in_frame && rises == 7) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) fail_now("mid_frame_wait_timeout");
        @(posedge clk);
        #2 rst_i = 1'b1;
        frame_q.delete();
        #1;
        chk("mid_reset_cs", cs_o, 1'b1);
        chk("mid_reset_sck", sck_o, 1'b1);
        chk("mid_reset_avg", avg_o, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        frame_q.push_back(16'h0A50);
        @(negedge clk);
        chk("post_reset_avg_zero", avg_o, 0);
        wait_valids(1);
        chk("post_reset_frame_avg", avg_o, 41);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("no_overrun_default", ovr1, 0);

        n = 0;
        while (!dut2_done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!dut2_done) fail_now("overrun_inst_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/als_meter_avg.md
Name: als_meter_avg

Overview:
- Next-generation ambient-light meter for the PMOD ALS sensor; contains its own SPI reader.
- Reads the sensor periodically and smooths the samples with a power-of-two moving average.
- Drives a parametrised LED bank in one of two run-time modes: PWM brightness on all LEDs, or a thermometer bar graph.
- Sits at the top of the light-measurement path, directly on board pins.

Parameters:
- NUM_LEDS, 8: number of LED outputs, 1..16.
- SAMPLE_PERIOD, 200: clk_i cycles between read requests, >= 2.
- SCK_DIV, 4: clk_i cycles per SCK half-period, >= 2.
- AVG_LOG2, 2: the average spans 2^AVG_LOG2 samples, 0..4.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- mode_i  in  1  0 = PWM mode, 1 = bar-graph mode; sampled every cycle.
- leds_o  out  NUM_LEDS  LED drive.
- avg_o  out  8  current averaged light value.
- avg_valid_o  out  1  one-cycle strobe when avg_o updates.
- overrun_o  out  1  one-cycle strobe when a read request is dropped.
- cs_o  out  1  SPI chip select, active low.
- sck_o  out  1  SPI clock, idles high.
- sdo_i  in  1  SPI data from the sensor.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - Outputs: cs_o=1, sck_o=1, leds_o=0, avg_o=0, avg_valid_o=0, overrun_o=0.
  - Internal state: all counters, the sample buffer, the sum and the FSM are cleared; FSM goes to IDLE.
  - Reset asserted mid-frame aborts the frame immediately; no sample is written.
- Request timer:
  - Counts 0..SAMPLE_PERIOD-1 and wraps.
  - A request fires in the cycle the count is 0; the first request is in the first cycle after reset release.
  - If the FSM is not IDLE when a request fires, the request is dropped and overrun_o pulses in that cycle.
- SPI FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
  - IDLE: cs_o=1. On a request, drive cs_o=0 and go to SETUP.
  - SETUP: lasts SCK_DIV cycles, then go to SHIFT.
  - SHIFT: 16 SCK periods. sck_o goes low for SCK_DIV cycles, then high for SCK_DIV cycles. sdo_i is sampled in the cycle sck_o rises and shifted in MSB-first. After the 16th rising edge, go to HOLD.
  - HOLD: sck_o=1 and cs_o=1 for SCK_DIV cycles, then go to DONE.
  - DONE: one cycle. Sample = frame bits [11:4]. Go to IDLE.
  - Frame length at default parameters: 4 + 128 + 4 + 1 = 137 cycles.
- Averager:
  - Circular buffer of 2^AVG_LOG2 entries, each 8 bits, cleared to 0 at reset.
  - Running sum is 8+AVG_LOG2 bits wide.
  - On each new sample: sum <= sum + sample - oldest entry; sample overwrites the oldest entry; write pointer increments and wraps.
  - Next cycle: avg_o = sum >> AVG_LOG2 and avg_valid_o=1.
  - Total latency is 1 cycle from DONE to avg_valid_o.
  - Ramp from a zero buffer after reset is intended behaviour.
  - The sum never overflows, because every buffer entry is <= 255.
- PWM mode:
  - 8-bit free-running counter pcnt, 0..255, wrapping.
  - duty is latched from avg_o only when pcnt==255, so the change is glitch-free at the period boundary.
  - All LEDs = (pcnt < duty). duty 0 gives always off; duty 255 gives 255 of every 256 cycles on.
- Bar mode:
  - lit = (avg_o * (NUM_LEDS+1)) >> 8.
  - leds_o[i] = (i < lit); LED 0 is the first to light.
  - avg 0 gives 0 LEDs lit; avg 255 with NUM_LEDS=8 gives 8 lit.
- Mode switching:
  - Takes effect on leds_o in the next cycle (output registered).
  - The PWM counter keeps running in both modes.

Optional Feature:
- Macro: ALS_PEAK_HOLD_EN.
- When defined:
  - Adds input peak_clr_i (1 bit) and output peak_o (8 bits, reset 0).
  - On each avg_valid_o, peak_o <= max(peak_o, avg_o).
  - peak_clr_i=1 loads peak_o <= avg_o; this has priority over the max update.
  - In bar mode, LED index ((peak_o*(NUM_LEDS+1))>>8)-1 is also lit when that index is >= 0.
- When undefined: the ports, the peak register and the peak-dot logic are absent.

Test Plan:
- Reset release with sdo_i driving frame 0x0FF0 → first cs_o fall in cycle 1 after release; 16 sck_o rises; cs_o high 132 cycles after falling; avg_o=63 (255>>2, AVG_LOG2=2), then 127, 191, 255 over successive frames.
- Constant frame value 0x0800 (sample 0x80) for 4 frames, then 0x0000 → avg_o 32, 64, 96, 128, then 96; each update has exactly one avg_valid_o pulse.
- SAMPLE_PERIOD=100 override → overrun_o pulses once per second request; frames never overlap; cs_o never glitches.
- Bar mode, NUM_LEDS=8, avg_o forced through 0, 28, 29, 128, 255 → lit = 0, 0, 1, 4, 8 LEDs, filled from LED 0.
- PWM mode with avg_o=64 → leds_o all high for exactly 64 of each 256 cycles; an avg_o change mid-period alters duty only after pcnt wraps.
- Reset asserted in SHIFT at bit 7 → cs_o=1 and sck_o=1 in the same cycle; avg_o stays 0; the next frame after release is complete and correct.
